// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller, datapath and ALU control.
// S_EXEC_I exists only when CTRL_IMM_ALU_EN is defined.
package ctrl_pkg;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_LD     = 7'b0000011;
  localparam logic [6:0] OPC_SD     = 7'b0100011;
  localparam logic [6:0] OPC_BEQ    = 7'b1100011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Fixed encodings so state values do not shift with the build option.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
`ifdef CTRL_IMM_ALU_EN
    S_EXEC_I   = 4'd7,
`endif
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: asynchronous clear, +1 per enabled cycle, wraps.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V main controller: Moore FSM sequencing fetch..write-back.
// Define CTRL_IMM_ALU_EN to decode I-type ALU ops (0010011) instead of trapping.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC on mem_ready
// DECODE   | branch target into ALU-out, dispatch on opcode
// MEM_ADDR | rs1 + imm for LD/SD
// MEM_RD   | load data read, wait mem_ready
// MEM_WB   | MDR into register file (retire)
// MEM_WR   | store write, wait mem_ready (retire on ready)
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm (CTRL_IMM_ALU_EN only)
// ALU_WB   | ALU-out into register file (retire)
// BRANCH   | compare, conditional PC load (retire)
// TRAP     | unknown opcode, absorbing until reset
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          aluop,
  output logic                illegal,
  output logic [CNT_W-1:0]    instret
);

  state_e r_state;
  state_e w_next;
  logic   r_run;

  logic       w_pc_write, w_pc_write_cond, w_pc_source, w_iord;
  logic       w_mem_read, w_mem_write, w_ir_write, w_mem_to_reg;
  logic       w_reg_write, w_alu_src_a, w_illegal, w_retire;
  logic [1:0] w_alu_src_b, w_aluop;

  // zero is consumed by the datapath's pc_write_cond gating, not here.
  logic w_unused;
  assign w_unused = zero;

  // r_run holds the FSM idle until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_state <= w_next;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_LD, OPC_SD: w_next = S_MEM_ADDR;
          OPC_R_TYPE:     w_next = S_EXEC_R;
`ifdef CTRL_IMM_ALU_EN
          OPC_I_ALU:      w_next = S_EXEC_I;
`endif
          OPC_BEQ:        w_next = S_BRANCH;
          default:        w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: w_next = (opcode == OPC_SD) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_EXEC_R:   w_next = S_ALU_WB;
`ifdef CTRL_IMM_ALU_EN
      S_EXEC_I:   w_next = S_ALU_WB;
`endif
      S_ALU_WB:   w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_RS2;
    w_aluop         = ALUOP_ADD;
    w_illegal       = 1'b0;
    w_retire        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
      end
      S_DECODE:   w_alu_src_b = SRCB_IMM;
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        w_retire    = mem_ready;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_aluop     = ALUOP_FUNCT;
      end
`ifdef CTRL_IMM_ALU_EN
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_aluop     = ALUOP_FUNCT;
      end
`endif
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_aluop         = ALUOP_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 1'b1;
        w_retire        = 1'b1;
      end
      S_TRAP:   w_illegal = 1'b1;
      default:  w_illegal = 1'b1;
    endcase
  end

  assign pc_write      = r_run & w_pc_write;
  assign pc_write_cond = r_run & w_pc_write_cond;
  assign pc_source     = r_run & w_pc_source;
  assign iord          = r_run & w_iord;
  assign mem_read      = r_run & w_mem_read;
  assign mem_write     = r_run & w_mem_write;
  assign ir_write      = r_run & w_ir_write;
  assign mem_to_reg    = r_run & w_mem_to_reg;
  assign reg_write     = r_run & w_reg_write;
  assign alu_src_a     = r_run & w_alu_src_a;
  assign alu_src_b     = r_run ? w_alu_src_b : 2'b00;
  assign aluop         = r_run ? w_aluop : 2'b00;
  assign illegal       = r_run & w_illegal;

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk    (clk),
    .rst    (reset),
    .i_inc  (r_run & w_retire),
    .o_count(instret)
  );

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle main decoder for the RISC-V core. It sequences each instruction through fetch, decode, execute, memory and write-back states over a shared memory port and a single ALU. It waits on a memory-ready handshake, traps on unknown opcodes and counts retired instructions. It sits between the instruction register opcode field and the multi-cycle datapath muxes, register-file write enable and memory port.

## Interface
- OPCODE_W, 7, opcode field width
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  OPCODE_W  opcode from instruction register (valid from DECODE on)
- zero  in  1  ALU zero flag (used only via pc_write_cond gating in datapath)
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- pc_source  out  1  0: ALU result, 1: ALU-out register (branch target)
- iord  out  1  memory address select, 0: PC, 1: ALU-out
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back select, 0: ALU-out, 1: MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0: PC, 1: rs1
- alu_src_b  out  2  00: rs2, 01: constant 4, 10: immediate
- aluop  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- illegal  out  1  sticky trap flag
- instret  out  CNT_W  retired-instruction count

## Operation
- Opcodes: R_TYPE 0110011, LD 0000011, SD 0100011, BEQ 1100011, I_ALU 0010011 (macro-gated).
- Moore FSM. All outputs decode from the state register, except the FETCH/MEM_RD/MEM_WR qualifiers listed below.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=0.
  - ir_write=mem_ready; pc_write=mem_ready.
  - Stay until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, aluop=00 (branch target into ALU-out).
  - Next state by opcode: LD/SD→MEM_ADDR, R_TYPE→EXEC_R, I_ALU→EXEC_I, BEQ→BRANCH, anything else→TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=00. LD→MEM_RD, SD→MEM_WR.
- MEM_RD: mem_read=1, iord=1. Stay until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Retire. Go to FETCH.
- MEM_WR: mem_write=1, iord=1. Stay until mem_ready; retire on mem_ready. Go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, aluop=10. Go to ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, aluop=10. Go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Retire. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=1. Retire. Go to FETCH.
- TRAP: all enables 0, illegal=1. Absorbing until reset; instret frozen.
- Unlisted outputs are 0 in every state. No x values are driven.
- instret increments by 1 in each retire cycle and wraps modulo 2^CNT_W.

## Timing
- While reset is high, state=FETCH internally but every output is forced to 0, instret=0 and illegal=0.
- The first FETCH cycle begins at the first rising edge after reset deasserts.
- Reset asserted mid-instruction aborts immediately (asynchronous). No retire is counted for the aborted instruction.
- Cycles per instruction with mem_ready tied high: BEQ 3, R/I/SD 4, LD 5.
- Each cycle mem_ready is low adds one cycle in FETCH, MEM_RD or MEM_WR.
- mem_ready is ignored outside those three states.
- instret updates on the clock edge ending the retire state, so it is visible the following cycle.

## Configuration
- CTRL_IMM_ALU_EN defined: opcode 0010011 decodes to EXEC_I.
- CTRL_IMM_ALU_EN undefined: EXEC_I is not built, and 0010011 goes to TRAP like any unknown opcode.

## Structure
- Shared package ctrl_pkg holds:
  - the opcode constants;
  - the state enum;
  - alu_src_b and aluop encodings.
- The datapath and ALU control consume those same encodings from ctrl_pkg.
- One sub-module, retire_counter: CNT_W-bit counter with asynchronous clear and increment enable.
- The FSM and output decode stay in multicycle_control.

## Test plan
- Reset release, mem_ready=1, opcode=0110011 → FETCH, DECODE, EXEC_R, ALU_WB. reg_write high in cycle 4 only; instret 0→1.
- LD with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total. ir_write pulses once, and exactly in the mem_ready cycle.
- SD then BEQ back-to-back, mem_ready=1 → mem_write high one cycle, iord=1 with it; BEQ asserts pc_write_cond with aluop=01. instret=2 after 7 cycles.
- Opcode 1111111 → TRAP after DECODE. illegal stays 1 for 20 cycles with all enables 0. Reset clears illegal and state returns to FETCH.
- Opcode 0010011 → with CTRL_IMM_ALU_EN defined: 4-cycle retire with alu_src_b=10 in EXEC_I. Without it: TRAP.
- Reset pulse during MEM_RD → outputs forced 0 immediately, instret keeps its reset value 0, and FETCH restarts after release.
